solution_receiver: RTL and testbench
====================================

Name: solution_receiver

Overview:
- Receive-side counterpart of the solution assembler. Consumes the byte stream the assembler emits, after uart_rx recovers it, and rebuilds the m x n solution bitmap.
- Used in the loopback self-test build and by the on-board result checker.
- Sits directly downstream of uart_rx. Presents a registered solution vector plus dimensions with a one-cycle done pulse.

Parameters:
- MAX_ROWS, 11, maximum board rows accepted.
- MAX_COLS, 11, maximum board columns accepted.
- TIMEOUT_CYCLES, 10_000_000, idle clocks allowed between bytes of one frame before abort (100 ms at 100 MHz).

Ports:
- clk_100mhz  input  1  system clock, 100 MHz.
- rst  input  1  synchronous, active-high reset.
- byte_in  input  8  received byte from uart_rx.
- valid_in  input  1  one-cycle strobe; byte_in is valid this cycle.
- solution  output  MAX_ROWS*MAX_COLS  cell r*n+c at bit index r*n+c; 1 = filled.
- m  output  $clog2(MAX_ROWS)  row count of the last good frame.
- n  output  $clog2(MAX_COLS)  column count of the last good frame.
- done  output  1  one-cycle pulse; a new frame has been committed.
- error  output  1  one-cycle pulse; frame rejected or timed out.
- busy  output  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Frame format:
  - byte0 = m, byte1 = n.
  - Then K = ceil(m*n/8) data bytes.
  - Cells are packed LSB-first: bit b of data byte j is cell 8j+b.
- Reset: solution=0, m=0, n=0, done=0, error=0, busy=0, state=IDLE, timeout counter=0, shadow buffer=0.
- States: IDLE -> GET_N -> DATA -> COMMIT -> IDLE.
  - IDLE: on valid_in, latch byte_in as m_tmp.
    - If 1 <= byte_in <= MAX_ROWS: go to GET_N.
    - Otherwise pulse error next cycle and stay in IDLE.
  - GET_N: on valid_in, latch n_tmp.
    - If 1 <= byte_in <= MAX_COLS: compute K with 7-bit arithmetic (m*n <= 121, K <= 16), clear shadow buffer and byte index, go to DATA.
    - Otherwise pulse error and go to IDLE.
  - DATA: on each valid_in, write byte_in into shadow bits [8*idx +: 8], masking bits at or above m_tmp*n_tmp to 0; increment idx.
    - When the byte with idx==K-1 is accepted, go to COMMIT.
  - COMMIT: single cycle. Copy shadow to solution and m_tmp/n_tmp to m/n, assert done for exactly this cycle, return to IDLE.
- Latency: done is high on the cycle after the clock edge that accepts the final data byte. solution, m and n are valid on that same cycle.
- Outputs hold the last committed frame until the next COMMIT. Rejected or aborted frames never modify solution, m or n.
- Timeout:
  - Counter clears on every accepted byte and on entry to IDLE.
  - Counter increments while in GET_N or DATA.
  - Reaching TIMEOUT_CYCLES-1 pulses error, discards the shadow buffer and returns to IDLE.
  - If valid_in coincides with the timeout cycle, the byte is accepted and the timeout is suppressed.
- valid_in during COMMIT is treated as byte0 of a new frame and evaluated with the IDLE rules. Back-to-back frames lose no bytes.
- Shadow writes beyond bit MAX_ROWS*MAX_COLS-1 are discarded. The final byte may hold up to 7 padding bits; these are ignored.
- done and error are never high in the same cycle.
- rst asserted mid-frame returns to IDLE within one cycle and clears all outputs per reset values.

Test Plan:
- 11x11 frame: bytes 0x0B, 0x0B, then 16 data bytes 0x01..0x10 -> done pulses once, one cycle after byte 18; m=11, n=11; solution[7:0]=0x01; solution[127:120] drops bits above 120, so solution[120]=0 (from byte 0x10, bit 0).
- 3x2 frame: 0x03, 0x02, 0xFF -> done; solution=0x3F; all higher bits 0.
- Bad dimensions: byte0=0x00 -> error pulse, stays in IDLE. Byte0=0x05, byte1=0x0C -> error, prior solution unchanged.
- Timeout: 0x04, 0x04, one data byte, then silence for TIMEOUT_CYCLES -> error pulse, busy falls, outputs unchanged. A following valid 4x4 frame (0x04, 0x04, 0xAA, 0x55) -> done with solution=0x55AA.
- Back-to-back: second frame's byte0 arrives on the COMMIT cycle of the first -> both frames complete, two done pulses.
- Reset mid-frame: assert rst after byte 5 of an 11x11 frame -> all outputs 0, IDLE; a subsequent full frame is received correctly.

Source files
------------

// File: rtl/solution_receiver.sv
// Rebuilds the m x n solution bitmap from the framed byte stream recovered by uart_rx.
// Frame: m, n, then ceil(m*n/8) data bytes packed LSB-first; committed with a one-cycle done.
module solution_receiver #(
    parameter int MAX_ROWS       = 11,
    parameter int MAX_COLS       = 11,
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input  logic                           clk_100mhz,
    input  logic                           rst,
    input  logic [7:0]                     byte_in,
    input  logic                           valid_in,
    output logic [MAX_ROWS*MAX_COLS-1:0]   solution,
    output logic [$clog2(MAX_ROWS)-1:0]    m,
    output logic [$clog2(MAX_COLS)-1:0]    n,
    output logic                           done,
    output logic                           error,
    output logic                           busy
);

    localparam int MW    = $clog2(MAX_ROWS);
    localparam int NW    = $clog2(MAX_COLS);
    localparam int CELLS = MAX_ROWS * MAX_COLS;
    localparam int CW    = $clog2(CELLS + 1);
    localparam int KMAX  = (CELLS + 7) / 8;
    localparam int KW    = $clog2(KMAX + 1);
    localparam int TW    = $clog2(TIMEOUT_CYCLES);

    localparam logic [7:0] MAX_ROWS_B = 8'(MAX_ROWS);
    localparam logic [7:0] MAX_COLS_B = 8'(MAX_COLS);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GET_N  = 2'd1;
    localparam logic [1:0] ST_DATA   = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    logic [1:0]       r_state;
    logic [TW-1:0]    r_cnt;
    logic [MW-1:0]    r_m_tmp;
    logic [NW-1:0]    r_n_tmp;
    logic [CW-1:0]    r_cells;
    logic [KW-1:0]    r_k;
    logic [KW-1:0]    r_idx;
    logic [CELLS-1:0] r_shadow;
    logic [CELLS-1:0] r_solution;
    logic [MW-1:0]    r_m;
    logic [NW-1:0]    r_n;
    logic             r_error;

    logic             w_m_ok;
    logic             w_n_ok;
    logic [CW-1:0]    w_cells;
    logic [CW:0]      w_cells_p7;
    logic [KW-1:0]    w_k;
    logic             w_timeout;
    logic             w_last;
    logic [CELLS-1:0] w_shadow_wr;

    assign w_m_ok     = (byte_in != 8'd0) && (byte_in <= MAX_ROWS_B);
    assign w_n_ok     = (byte_in != 8'd0) && (byte_in <= MAX_COLS_B);
    assign w_cells    = CW'(r_m_tmp) * CW'(byte_in[NW-1:0]);
    assign w_cells_p7 = {1'b0, w_cells} + (CW + 1)'(7);
    assign w_k        = KW'(w_cells_p7 >> 3);
    assign w_timeout  = (r_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign w_last     = (r_idx == r_k - KW'(1));

    // Only cells below m*n of the current byte slot are written; padding stays 0.
    always_comb begin
        w_shadow_wr = r_shadow;
        for (int c = 0; c < CELLS; c++) begin
            if ((c / 8) == int'(r_idx) && c < int'(r_cells)) begin
                w_shadow_wr[c] = byte_in[c % 8];
            end
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_m_tmp    <= '0;
            r_n_tmp    <= '0;
            r_cells    <= '0;
            r_k        <= '0;
            r_idx      <= '0;
            r_shadow   <= '0;
            r_solution <= '0;
            r_m        <= '0;
            r_n        <= '0;
            r_error    <= 1'b0;
        end else begin
            r_error <= 1'b0;
            case (r_state)
                // COMMIT takes a new byte0 exactly like IDLE so back-to-back frames lose nothing.
                ST_IDLE, ST_COMMIT: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                    if (valid_in) begin
                        r_m_tmp <= byte_in[MW-1:0];
                        if (w_m_ok) begin
                            r_state <= ST_GET_N;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                ST_GET_N: begin
                    if (valid_in) begin
                        r_cnt   <= '0;
                        r_n_tmp <= byte_in[NW-1:0];
                        if (w_n_ok) begin
                            r_cells  <= w_cells;
                            r_k      <= w_k;
                            r_idx    <= '0;
                            r_shadow <= '0;
                            r_state  <= ST_DATA;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end else if (w_timeout) begin
                        r_error <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (valid_in) begin
                        r_cnt    <= '0;
                        r_shadow <= w_shadow_wr;
                        r_idx    <= r_idx + KW'(1);
                        if (w_last) begin
                            r_solution <= w_shadow_wr;
                            r_m        <= r_m_tmp;
                            r_n        <= r_n_tmp;
                            r_state    <= ST_COMMIT;
                        end
                    end else if (w_timeout) begin
                        r_error  <= 1'b1;
                        r_cnt    <= '0;
                        r_shadow <= '0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + TW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign solution = r_solution;
    assign m        = r_m;
    assign n        = r_n;
    assign done     = (r_state == ST_COMMIT);
    assign error    = r_error;
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_solution_receiver.sv
// Bench for solution_receiver: directed vector table, hand-written corner sequences and
// random frames, all checked against a byte-queue reference model of the frame rules.
module tb_solution_receiver;

    localparam int MR    = 11;
    localparam int MC    = 11;
    localparam int TO    = 64;
    localparam int CELLS = MR * MC;

    logic             clk_100mhz = 1'b0;
    logic             rst        = 1'b1;
    logic [7:0]       byte_in    = 8'h00;
    logic             valid_in   = 1'b0;
    logic [CELLS-1:0] solution;
    logic [3:0]       m;
    logic [3:0]       n;
    logic             done;
    logic             error;
    logic             busy;

    always #5 clk_100mhz = ~clk_100mhz;

    solution_receiver #(
        .MAX_ROWS       (MR),
        .MAX_COLS       (MC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .byte_in    (byte_in),
        .valid_in   (valid_in),
        .solution   (solution),
        .m          (m),
        .n          (n),
        .done       (done),
        .error      (error),
        .busy       (busy)
    );

    int checks    = 0;
    int failures  = 0;
    int done_seen = 0;

    // Reference model: frame in progress is just the list of bytes received so far.
    bit               md_in_frame;
    logic [7:0]       md_q[$];
    int               md_idle;
    logic [CELLS-1:0] ex_sol;
    logic [3:0]       ex_m;
    logic [3:0]       ex_n;
    bit               ex_done;
    bit               ex_err;
    bit               ex_busy;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 50) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    function automatic void model_step(input bit r, input bit v, input logic [7:0] b);
        int mm;
        int nn;
        int k;
        logic [7:0] d;
        if (r) begin
            md_in_frame = 1'b0;
            md_q.delete();
            md_idle = 0;
            ex_sol  = '0;
            ex_m    = '0;
            ex_n    = '0;
            ex_done = 1'b0;
            ex_err  = 1'b0;
            ex_busy = 1'b0;
            return;
        end
        ex_done = 1'b0;
        ex_err  = 1'b0;
        if (!md_in_frame) begin
            if (v) begin
                if (b >= 8'd1 && b <= 8'(MR)) begin
                    md_in_frame = 1'b1;
                    md_q.delete();
                    md_q.push_back(b);
                    md_idle = 0;
                end else begin
                    ex_err = 1'b1;
                end
            end
        end else if (v) begin
            md_q.push_back(b);
            md_idle = 0;
            if (md_q.size() == 2) begin
                if (!(b >= 8'd1 && b <= 8'(MC))) begin
                    ex_err      = 1'b1;
                    md_in_frame = 1'b0;
                end
            end else begin
                mm = int'(md_q[0]);
                nn = int'(md_q[1]);
                k  = (mm * nn + 7) / 8;
                if (md_q.size() == 2 + k) begin
                    ex_sol = '0;
                    for (int i = 0; i < mm * nn; i++) begin
                        d = md_q[2 + i / 8];
                        ex_sol[i] = d[i % 8];
                    end
                    ex_m        = 4'(mm);
                    ex_n        = 4'(nn);
                    ex_done     = 1'b1;
                    md_in_frame = 1'b0;
                end
            end
        end else begin
            md_idle++;
            if (md_idle == TO) begin
                ex_err      = 1'b1;
                md_in_frame = 1'b0;
            end
        end
        ex_busy = md_in_frame || ex_done;
    endfunction

    task automatic step(input bit r, input bit v, input logic [7:0] b, input string nm);
        rst      = r;
        valid_in = v;
        byte_in  = b;
        @(posedge clk_100mhz);
        model_step(r, v, b);
        @(negedge clk_100mhz);
        if (done) done_seen++;
        chk({nm, " done"},     128'(done),     128'(ex_done));
        chk({nm, " error"},    128'(error),    128'(ex_err));
        chk({nm, " busy"},     128'(busy),     128'(ex_busy));
        chk({nm, " m"},        128'(m),        128'(ex_m));
        chk({nm, " n"},        128'(n),        128'(ex_n));
        chk({nm, " solution"}, 128'(solution), 128'(ex_sol));
    endtask

    task automatic send(input logic [7:0] b, input string nm);
        int g;
        g = ($urandom_range(0, 15) == 0) ? TO - 1 : int'($urandom_range(0, 2));
        repeat (g) step(1'b0, 1'b0, 8'($urandom), {nm, " idle"});
        step(1'b0, 1'b1, b, nm);
    endtask

    task automatic rand_frame();
        int kind;
        int mm;
        int nn;
        int k;
        kind = int'($urandom_range(0, 99));
        mm   = int'($urandom_range(1, MR));
        nn   = int'($urandom_range(1, MC));
        if (kind < 8) mm = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MR + 1, 255));
        send(8'(mm), "rand m");
        if (kind < 8) return;
        if (kind < 14) nn = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MC + 1, 255));
        send(8'(nn), "rand n");
        if (kind < 14) return;
        k = (mm * nn + 7) / 8;
        for (int j = 0; j < k; j++) begin
            if (kind < 18 && j == k / 2) begin
                repeat (TO + 2) step(1'b0, 1'b0, 8'($urandom), "rand timeout");
                return;
            end
            if (kind < 20 && j == k / 2) begin
                step(1'b1, 1'b0, 8'h00, "rand reset");
                return;
            end
            send(8'($urandom), "rand data");
        end
    endtask

    typedef struct {
        bit         r;
        bit         v;
        logic [7:0] b;
        bit         d;
        bit         e;
        bit         bz;
        logic [3:0] m;
        logic [3:0] n;
        logic [15:0] sol;
    } vec_t;

    vec_t tbl[15];
    int   waited;
    bit   seen;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 16'h0000};
        tbl[1]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 16'h0000};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 16'h0000};
        tbl[3]  = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 16'h0000};
        tbl[4]  = '{1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 16'h0000};
        tbl[5]  = '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 4'd3, 4'd2, 16'h003F};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd3, 4'd2, 16'h003F};
        tbl[7]  = '{1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 4'd3, 4'd2, 16'h003F};
        tbl[8]  = '{1'b0, 1'b1, 8'h0C, 1'b0, 1'b1, 1'b0, 4'd3, 4'd2, 16'h003F};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd3, 4'd2, 16'h003F};
        tbl[10] = '{1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 4'd3, 4'd2, 16'h003F};
        tbl[11] = '{1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 4'd3, 4'd2, 16'h003F};
        tbl[12] = '{1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 4'd3, 4'd2, 16'h003F};
        tbl[13] = '{1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 4'd4, 4'd4, 16'h55AA};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd4, 4'd4, 16'h55AA};

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].b, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d tbl done", i),  128'(done),     128'(tbl[i].d));
            chk($sformatf("vec%0d tbl error", i), 128'(error),    128'(tbl[i].e));
            chk($sformatf("vec%0d tbl busy", i),  128'(busy),     128'(tbl[i].bz));
            chk($sformatf("vec%0d tbl m", i),     128'(m),        128'(tbl[i].m));
            chk($sformatf("vec%0d tbl n", i),     128'(n),        128'(tbl[i].n));
            chk($sformatf("vec%0d tbl sol", i),   128'(solution), 128'(tbl[i].sol));
        end

        // Full 11x11 frame: last byte 0x10 carries cells 120..127, only 120 survives.
        step(1'b0, 1'b1, 8'd11, "big m");
        step(1'b0, 1'b1, 8'd11, "big n");
        for (int j = 1; j <= 16; j++) step(1'b0, 1'b1, 8'(j), "big data");
        chk("big done",        128'(done),              128'(1));
        chk("big m value",     128'(m),                 128'(11));
        chk("big sol[7:0]",    128'(solution[7:0]),     128'(8'h01));
        chk("big sol[119:112]", 128'(solution[119:112]), 128'(8'h0F));
        chk("big sol[120]",    128'(solution[120]),     128'(0));
        step(1'b0, 1'b0, 8'h00, "big after");

        // Timeout after one data byte.
        step(1'b0, 1'b1, 8'h04, "tmo m");
        step(1'b0, 1'b1, 8'h04, "tmo n");
        step(1'b0, 1'b1, 8'h12, "tmo data");
        waited = 0;
        seen   = 1'b0;
        for (int i = 0; i < TO + 4 && !seen; i++) begin
            step(1'b0, 1'b0, 8'h00, "tmo wait");
            waited++;
            if (error) seen = 1'b1;
        end
        chk("tmo error seen",   128'(seen),   128'(1));
        chk("tmo idle cycles",  128'(waited), 128'(TO));
        chk("tmo busy low",     128'(busy),   128'(0));
        chk("tmo m unchanged",  128'(m),      128'(11));

        // Bytes arriving exactly on the timeout cycle are accepted.
        step(1'b0, 1'b1, 8'h04, "edge m");
        step(1'b0, 1'b1, 8'h04, "edge n");
        repeat (TO - 1) step(1'b0, 1'b0, 8'h00, "edge gap");
        step(1'b0, 1'b1, 8'hAA, "edge d0");
        repeat (TO - 1) step(1'b0, 1'b0, 8'h00, "edge gap");
        step(1'b0, 1'b1, 8'h55, "edge d1");
        chk("edge done",     128'(done),     128'(1));
        chk("edge solution", 128'(solution), 128'(16'h55AA));

        // Back-to-back: second byte0 lands on the COMMIT cycle of the first frame.
        done_seen = 0;
        step(1'b0, 1'b1, 8'h03, "b2b");
        step(1'b0, 1'b1, 8'h02, "b2b");
        step(1'b0, 1'b1, 8'hFF, "b2b");
        step(1'b0, 1'b1, 8'h02, "b2b");
        step(1'b0, 1'b1, 8'h02, "b2b");
        step(1'b0, 1'b1, 8'h0A, "b2b");
        step(1'b0, 1'b0, 8'h00, "b2b");
        chk("b2b done count", 128'(done_seen), 128'(2));
        chk("b2b solution",   128'(solution),  128'(4'hA));

        // Reset after byte 5 of an 11x11 frame, then a full good frame.
        step(1'b0, 1'b1, 8'd11, "rst frame");
        step(1'b0, 1'b1, 8'd11, "rst frame");
        for (int j = 0; j < 3; j++) step(1'b0, 1'b1, 8'($urandom), "rst frame");
        step(1'b1, 1'b0, 8'h00, "rst mid");
        chk("rst solution", 128'(solution), 128'(0));
        chk("rst m",        128'(m),        128'(0));
        chk("rst busy",     128'(busy),     128'(0));
        step(1'b0, 1'b1, 8'd11, "post rst");
        step(1'b0, 1'b1, 8'd11, "post rst");
        for (int j = 0; j < 16; j++) step(1'b0, 1'b1, 8'($urandom), "post rst");
        chk("post rst done", 128'(done), 128'(1));

        for (int f = 0; f < 250; f++) rand_frame();
        repeat (TO + 2) step(1'b0, 1'b0, 8'h00, "drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
